memory_queue: RTL and testbench

- Parametrised successor to the single-word 35-bit hold register: a DEPTH-entry, WIDTH-bit synchronous FIFO with valid/ready handshakes on both sides.
- Sits between a producer datapath stage and a consumer stage, buffering words that a single register would otherwise overwrite.
- Adds occupancy count, full/empty/almost-full flags, a synchronous clear, and sticky overflow/underflow error flags.

---
 rtl/memory_queue.sv | 103 ++++++++++
 tb/tb_memory_queue.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/memory_queue.sv
// Synchronous show-ahead FIFO with valid/ready handshakes on both sides.
// Occupancy is tracked by an explicit counter, and all status flags are decoded from that counter.
module memory_queue #(
    parameter int WIDTH    = 35,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6
) (
    input  logic                       clk,
    input  logic                       arst,
    input  logic                       clr,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [WIDTH-1:0]           wr_data,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       err_ovf,
    output logic                       err_udf
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          err_ovf_q, err_ovf_d;
    logic          err_udf_q, err_udf_d;
    logic          wr_en;
    logic          rd_en;

    assign full        = (count_q == FULL_CNT);
    assign empty       = (count_q == '0);
    assign almost_full = (count_q >= AF_CNT);
    assign wr_ready    = ~full;
    assign rd_valid    = ~empty;
    assign count       = count_q;
    assign err_ovf     = err_ovf_q;
    assign err_udf     = err_udf_q;
    assign rd_data     = empty ? '0 : mem[rd_ptr_q];

    assign wr_en = wr_valid & ~full & ~clr;
    assign rd_en = rd_ready & ~empty & ~clr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        err_ovf_d = err_ovf_q | (wr_valid & full);
        err_udf_d = err_udf_q | (rd_ready & empty);
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (wr_en && !rd_en) begin
            count_d = count_q + CW'(1);
        end else if (rd_en && !wr_en) begin
            count_d = count_q - CW'(1);
        end
        if (clr) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            err_ovf_d = 1'b0;
            err_udf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            err_ovf_q <= 1'b0;
            err_udf_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            err_ovf_q <= err_ovf_d;
            err_udf_q <= err_udf_d;
        end
    end

    // The storage array has no reset; only accepted writes change its contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_memory_queue.sv
// Bench for memory_queue: directed scenarios followed by random traffic.
// Results are compared against a queue-based reference model.
module tb_memory_queue;

    localparam int WIDTH    = 35;
    localparam int DEPTH    = 8;
    localparam int AF_LEVEL = 6;
    localparam int CW       = $clog2(DEPTH+1);

    logic             clk;
    logic             arst;
    logic             clr;
    logic             wr_valid;
    logic             wr_ready;
    logic [WIDTH-1:0] wr_data;
    logic             rd_valid;
    logic             rd_ready;
    logic [WIDTH-1:0] rd_data;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             err_ovf;
    logic             err_udf;

    memory_queue #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .AF_LEVEL(AF_LEVEL)
    ) dut (
        .clk(clk),
        .arst(arst),
        .clr(clr),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_data(wr_data),
        .rd_valid(rd_valid),
        .rd_ready(rd_ready),
        .rd_data(rd_data),
        .count(count),
        .full(full),
        .empty(empty),
        .almost_full(almost_full),
        .err_ovf(err_ovf),
        .err_udf(err_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [WIDTH-1:0] model[$];
    logic             modelOvf;
    logic             modelUdf;
    int               checkCount;
    int               failCount;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Compares every output against what the reference queue implies.
    task automatic checkAll();
        int n;
        n = model.size();
        checkOutput("count", 64'(count), 64'(n));
        checkOutput("empty", 64'(empty), 64'(n == 0));
        checkOutput("full", 64'(full), 64'(n == DEPTH));
        checkOutput("almost_full", 64'(almost_full), 64'(n >= AF_LEVEL));
        checkOutput("wr_ready", 64'(wr_ready), 64'(n != DEPTH));
        checkOutput("rd_valid", 64'(rd_valid), 64'(n != 0));
        checkOutput("rd_data", 64'(rd_data), (n != 0) ? 64'(model[0]) : 64'h0);
        checkOutput("err_ovf", 64'(err_ovf), 64'(modelOvf));
        checkOutput("err_udf", 64'(err_udf), 64'(modelUdf));
    endtask

    // Drives one cycle of inputs, advances the model at the edge, then checks at the falling edge.
    task automatic applyStimulus(input logic wv, input logic [WIDTH-1:0] wd, input logic rr, input logic c);
        int  n;
        logic doWr;
        logic doRd;
        wr_valid = wv;
        wr_data  = wd;
        rd_ready = rr;
        clr      = c;
        @(posedge clk);
        n = model.size();
        if (c) begin
            model.delete();
            modelOvf = 1'b0;
            modelUdf = 1'b0;
        end else begin
            doWr = wv && (n < DEPTH);
            doRd = rr && (n > 0);
            if (wv && n == DEPTH) modelOvf = 1'b1;
            if (rr && n == 0) modelUdf = 1'b1;
            if (doRd) void'(model.pop_front());
            if (doWr) model.push_back(wd);
        end
        @(negedge clk);
        checkAll();
    endtask

    function automatic logic [WIDTH-1:0] randWord();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[WIDTH-1:0];
    endfunction

    initial begin
        checkCount = 0;
        failCount  = 0;
        modelOvf   = 1'b0;
        modelUdf   = 1'b0;
        arst       = 1'b1;
        clr        = 1'b0;
        wr_valid   = 1'b0;
        wr_data    = '0;
        rd_ready   = 1'b0;
        repeat (2) @(negedge clk);
        checkAll();
        arst = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, 1'b0);

        // Fill to full, then one overflowing write.
        for (int i = 1; i <= DEPTH; i++) begin
            applyStimulus(1'b1, WIDTH'(i), 1'b0, 1'b0);
        end
        checkOutput("fill_count", 64'(count), 64'(8));
        applyStimulus(1'b1, 35'h7FFFFFFFF, 1'b0, 1'b0);
        checkOutput("ovf_set", 64'(err_ovf), 64'(1));
        for (int i = 1; i <= DEPTH; i++) begin
            checkOutput("drain_order", 64'(rd_data), 64'(i));
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
        end

        // Concurrent traffic around pointer wraps.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, WIDTH'(100 + i), 1'b0, 1'b0);
        end
        for (int i = 3; i < 23; i++) begin
            applyStimulus(1'b1, WIDTH'(100 + i), 1'b1, 1'b0);
        end
        checkOutput("wrap_count", 64'(count), 64'(3));
        repeat (3) applyStimulus(1'b0, '0, 1'b1, 1'b0);

        // Write and read together while empty.
        applyStimulus(1'b1, 35'h123456789, 1'b1, 1'b0);
        checkOutput("race_data", 64'(rd_data), 64'h123456789);
        checkOutput("race_udf", 64'(err_udf), 64'(1));

        // Clear with count 5, overflow set, and a concurrent write.
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, randWord(), 1'b0, 1'b0);
        end
        repeat (3) applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("pre_clr_count", 64'(count), 64'(5));
        applyStimulus(1'b1, 35'h0DEADBEEF, 1'b0, 1'b1);
        checkOutput("clr_empty", 64'(empty), 64'(1));

        // Asynchronous reset between edges with four entries queued.
        repeat (4) applyStimulus(1'b1, randWord(), 1'b0, 1'b0);
        wr_valid = 1'b0;
        #2;
        arst = 1'b1;
        model.delete();
        modelOvf = 1'b0;
        modelUdf = 1'b0;
        #1;
        checkAll();
        #1;
        arst = 1'b0;
        applyStimulus(1'b1, 35'h2468ACE13, 1'b0, 1'b0);
        checkOutput("post_rst_data", 64'(rd_data), 64'h2468ACE13);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);

        // Random traffic with occasional clears.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(1'($urandom_range(0, 99) < 55), randWord(),
                          1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 63) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
